// File: rtl/i2s_sample_transmitter.sv
// I2S transmitter: derives bclk/lrclk frame timing from clk and
// serialises one latched mono sample into both slots, MSB first.
module i2s_sample_transmitter #(
  parameter int CLK_DIV      = 16,
  parameter int SAMPLE_WIDTH = 18
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [SAMPLE_WIDTH-1:0] sample_in,
  output logic                    new_frame,
  output logic                    bclk,
  output logic                    lrclk,
  output logic                    sdata
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
  localparam logic [4:0] SW = 5'(SAMPLE_WIDTH);

  logic [DW-1:0]           div_cnt, div_nxt;
  logic [5:0]              bit_cnt, bit_nxt, bit_inc;
  logic [SAMPLE_WIDTH-1:0] shadow, shadow_nxt;
  logic                    bclk_nxt, lrclk_nxt;
  logic                    sdata_nxt, frame_nxt;
  logic                    tick, fall;
  logic [4:0]              p, idx;

  always_comb begin
    tick       = (div_cnt == DIV_MAX);
    fall       = tick && bclk;
    bit_inc    = bit_cnt + 6'd1;
    p          = bit_inc[4:0];
    idx        = SW - p;
    div_nxt    = tick ? '0 : div_cnt + DW'(1);
    bclk_nxt   = bclk ^ tick;
    bit_nxt    = bit_cnt;
    lrclk_nxt  = lrclk;
    sdata_nxt  = sdata;
    frame_nxt  = 1'b0;
    shadow_nxt = shadow;
    if (fall) begin
      bit_nxt   = bit_inc;
      lrclk_nxt = bit_inc[5];
      sdata_nxt = 1'b0;
      // p=0 is the I2S one-bit delay slot after lrclk moves
      if (p != 5'd0 && p <= SW)
        sdata_nxt = shadow[idx];
      if (bit_inc == 6'd0) begin
        frame_nxt  = 1'b1;
        shadow_nxt = sample_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      div_cnt   <= '0;
      bit_cnt   <= 6'd63;
      bclk      <= 1'b0;
      lrclk     <= 1'b0;
      sdata     <= 1'b0;
      new_frame <= 1'b0;
      shadow    <= '0;
    end else begin
      div_cnt   <= div_nxt;
      bit_cnt   <= bit_nxt;
      bclk      <= bclk_nxt;
      lrclk     <= lrclk_nxt;
      sdata     <= sdata_nxt;
      new_frame <= frame_nxt;
      shadow    <= shadow_nxt;
    end
  end

endmodule

// File: tb/tb_i2s_sample_transmitter.sv
// Directed bench for i2s_sample_transmitter at CLK_DIV=2 and CLK_DIV=1.
// Expected serial words are hand-derived constants.
module tb_i2s_sample_transmitter;

  localparam int CD = 2;
  localparam int SW = 18;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          enable1;
  logic [SW-1:0] sample_in;
  logic          new_frame, bclk, lrclk, sdata;
  logic          nf1, bclk1, lr1, sd1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  i2s_sample_transmitter #(.CLK_DIV(CD), .SAMPLE_WIDTH(SW)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .sample_in(sample_in), .new_frame(new_frame),
    .bclk(bclk), .lrclk(lrclk), .sdata(sdata)
  );

  i2s_sample_transmitter #(.CLK_DIV(1), .SAMPLE_WIDTH(SW)) dut1 (
    .clk(clk), .reset(reset), .enable(enable1),
    .sample_in(sample_in), .new_frame(nf1),
    .bclk(bclk1), .lrclk(lr1), .sdata(sd1)
  );

  function automatic logic [31:0] fw(input logic [SW-1:0] s);
    return {1'b0, s, 13'b0};
  endfunction

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_frame(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      step();
      if (new_frame) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // starts at a frame-start sample point, ends at the next one
  task automatic capture(input int chg_at, input logic [SW-1:0] chg_val,
                         output logic [31:0] l, output logic [31:0] r,
                         output logic [63:0] lr);
    l = '0;
    r = '0;
    lr = '0;
    for (int c = 1; c <= 256; c++) begin
      step();
      if (c == chg_at) sample_in = chg_val;
      if (c % 4 == 1) begin
        int n;
        n = (c - 1) / 4;
        if (n < 32) l[31-n] = sdata;
        else        r[63-n] = sdata;
        lr[63-n] = lrclk;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    enable = 1'b1;
    enable1 = 1'b0;
    sample_in = '0;
    step(3);
    checks++;
    if (new_frame !== 1'b0) begin
      errors++;
      $display("FAIL reset_new_frame got=%b exp=0", new_frame);
    end
    checks++;
    if (bclk !== 1'b0) begin
      errors++;
      $display("FAIL reset_bclk got=%b exp=0", bclk);
    end
    checks++;
    if (lrclk !== 1'b0) begin
      errors++;
      $display("FAIL reset_lrclk got=%b exp=0", lrclk);
    end
    checks++;
    if (sdata !== 1'b0) begin
      errors++;
      $display("FAIL reset_sdata got=%b exp=0", sdata);
    end
  endtask

  task automatic test_frame_timing();
    int f1 = -1, f2 = -1, f3 = -1;
    int nf_cnt = 0, falls = 0, berr = 0, serr = 0;
    logic pb, plr, psd, eb;
    reset = 1'b0;
    pb = bclk;
    plr = lrclk;
    psd = sdata;
    for (int c = 1; c <= 600; c++) begin
      step();
      if (new_frame) begin
        nf_cnt++;
        if (f1 < 0) f1 = c;
        else if (f2 < 0) f2 = c;
        else if (f3 < 0) f3 = c;
      end
      eb = ((c / 2) % 2) != 0;
      if (bclk !== eb) berr++;
      if (pb && !bclk && c > 4 && c <= 260) falls++;
      if ((lrclk !== plr || sdata !== psd) && !(pb && !bclk)) serr++;
      pb = bclk;
      plr = lrclk;
      psd = sdata;
    end
    checks++;
    if (f1 != 4) begin
      errors++;
      $display("FAIL first_frame got=%0d exp=4", f1);
    end
    checks++;
    if (f2 != 260) begin
      errors++;
      $display("FAIL second_frame got=%0d exp=260", f2);
    end
    checks++;
    if (f3 != 516) begin
      errors++;
      $display("FAIL third_frame got=%0d exp=516", f3);
    end
    checks++;
    if (nf_cnt != 3) begin
      errors++;
      $display("FAIL new_frame_width high_cycles=%0d exp=3", nf_cnt);
    end
    checks++;
    if (falls != 64) begin
      errors++;
      $display("FAIL bclk_falls got=%0d exp=64", falls);
    end
    checks++;
    if (berr != 0) begin
      errors++;
      $display("FAIL bclk_waveform bad_cycles=%0d exp=0", berr);
    end
    checks++;
    if (serr != 0) begin
      errors++;
      $display("FAIL change_off_fall bad_cycles=%0d exp=0", serr);
    end
  endtask

  task automatic test_pattern();
    bit ok;
    logic [31:0] l, r;
    logic [63:0] lr;
    sample_in = 18'h2A5C3;
    wait_frame(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL pattern_wait got=timeout exp=new_frame");
    end
    capture(0, '0, l, r, lr);
    checks++;
    if (l !== {1'b0, 18'b101010010111000011, 13'b0}) begin
      errors++;
      $display("FAIL pattern_left got=%h exp=%h", l, fw(18'h2A5C3));
    end
    checks++;
    if (r !== {1'b0, 18'b101010010111000011, 13'b0}) begin
      errors++;
      $display("FAIL pattern_right got=%h exp=%h", r, fw(18'h2A5C3));
    end
    checks++;
    if (lr !== 64'h00000000_FFFFFFFF) begin
      errors++;
      $display("FAIL pattern_lrclk got=%h exp=00000000ffffffff", lr);
    end
    checks++;
    if (new_frame !== 1'b1) begin
      errors++;
      $display("FAIL pattern_next_frame got=%b exp=1", new_frame);
    end
  endtask

  task automatic test_sample_change();
    bit ok;
    logic [31:0] la, ra, lb, rb;
    logic [63:0] lr;
    sample_in = 18'h3FFFF;
    wait_frame(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL change_wait got=timeout exp=new_frame");
    end
    capture(2, 18'h00001, la, ra, lr);
    capture(0, 18'h00001, lb, rb, lr);
    checks++;
    if (la !== fw(18'h3FFFF)) begin
      errors++;
      $display("FAIL change_cur_left got=%h exp=%h", la, fw(18'h3FFFF));
    end
    checks++;
    if (ra !== fw(18'h3FFFF)) begin
      errors++;
      $display("FAIL change_cur_right got=%h exp=%h", ra, fw(18'h3FFFF));
    end
    checks++;
    if (lb !== 32'h0000_2000) begin
      errors++;
      $display("FAIL change_next_left got=%h exp=00002000", lb);
    end
    checks++;
    if (rb !== 32'h0000_2000) begin
      errors++;
      $display("FAIL change_next_right got=%h exp=00002000", rb);
    end
  endtask

  task automatic test_enable_drop();
    bit ok;
    int bad = 0, gap = -1;
    logic b2 = 1'b0;
    sample_in = 18'h1FFFF;
    wait_frame(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL drop_wait got=timeout exp=new_frame");
    end
    step(82);
    checks++;
    if (bclk !== 1'b1) begin
      errors++;
      $display("FAIL drop_pre_bclk got=%b exp=1", bclk);
    end
    enable = 1'b0;
    step();
    checks++;
    if ({new_frame, bclk, lrclk, sdata} !== 4'b0) begin
      errors++;
      $display("FAIL drop_outputs got=%b exp=0000",
               {new_frame, bclk, lrclk, sdata});
    end
    for (int i = 0; i < 9; i++) begin
      step();
      if ({new_frame, bclk, lrclk, sdata} !== 4'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL drop_idle bad_cycles=%0d exp=0", bad);
    end
    enable = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      step();
      if (c == 2) b2 = bclk;
      if (new_frame && gap < 0) gap = c;
    end
    checks++;
    if (gap != 2 * CD) begin
      errors++;
      $display("FAIL drop_restart_frame got=%0d exp=%0d", gap, 2 * CD);
    end
    checks++;
    if (b2 !== 1'b1) begin
      errors++;
      $display("FAIL drop_restart_bclk got=%b exp=1", b2);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int bad = 0;
    logic [31:0] l, r;
    logic [63:0] lr;
    sample_in = 18'h1FFFF;
    wait_frame(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL rst_wait got=timeout exp=new_frame");
    end
    step(150);
    checks++;
    if ({bclk, lrclk, sdata} !== 3'b111) begin
      errors++;
      $display("FAIL rst_pre got=%b exp=111", {bclk, lrclk, sdata});
    end
    reset = 1'b1;
    step();
    checks++;
    if ({new_frame, bclk, lrclk, sdata} !== 4'b0) begin
      errors++;
      $display("FAIL rst_outputs got=%b exp=0000",
               {new_frame, bclk, lrclk, sdata});
    end
    reset = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      step();
      if ({new_frame, lrclk, sdata} !== 3'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL rst_no_partial bad_cycles=%0d exp=0", bad);
    end
    step();
    checks++;
    if (new_frame !== 1'b1) begin
      errors++;
      $display("FAIL rst_restart_frame got=%b exp=1", new_frame);
    end
    capture(0, '0, l, r, lr);
    checks++;
    if (l !== fw(18'h1FFFF)) begin
      errors++;
      $display("FAIL rst_frame_left got=%h exp=%h", l, fw(18'h1FFFF));
    end
  endtask

  task automatic test_loopback();
    bit ok;
    logic [31:0] la, ra, lb, rb;
    logic [63:0] lr;
    sample_in = 18'h2A5C3;
    wait_frame(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL loop_wait got=timeout exp=new_frame");
    end
    capture(1, 18'h12345, la, ra, lr);
    capture(0, 18'h12345, lb, rb, lr);
    checks++;
    if (la !== fw(18'h2A5C3)) begin
      errors++;
      $display("FAIL loop_old_left got=%h exp=%h", la, fw(18'h2A5C3));
    end
    checks++;
    if (lb !== fw(18'h12345)) begin
      errors++;
      $display("FAIL loop_new_left got=%h exp=%h", lb, fw(18'h12345));
    end
    checks++;
    if (rb !== fw(18'h12345)) begin
      errors++;
      $display("FAIL loop_new_right got=%h exp=%h", rb, fw(18'h12345));
    end
  endtask

  task automatic test_clk_div1();
    int f1 = -1, f2 = -1, berr = 0;
    logic bf = 1'b1, s2 = 1'b1, s4 = 1'b0;
    reset = 1'b1;
    enable1 = 1'b1;
    step();
    checks++;
    if ({nf1, bclk1, lr1, sd1} !== 4'b0) begin
      errors++;
      $display("FAIL div1_reset got=%b exp=0000", {nf1, bclk1, lr1, sd1});
    end
    reset = 1'b0;
    for (int c = 1; c <= 300; c++) begin
      step();
      if (bclk1 !== ((c % 2) != 0)) berr++;
      if (nf1) begin
        if (f1 < 0) begin
          f1 = c;
          bf = bclk1;
        end else if (f2 < 0) f2 = c;
      end
      if (f1 > 0 && c == f1 + 2) s2 = sd1;
      if (f1 > 0 && c == f1 + 4) s4 = sd1;
    end
    checks++;
    if (f1 != 2) begin
      errors++;
      $display("FAIL div1_first_frame got=%0d exp=2", f1);
    end
    checks++;
    if (f2 != 130) begin
      errors++;
      $display("FAIL div1_second_frame got=%0d exp=130", f2);
    end
    checks++;
    if (bf !== 1'b0) begin
      errors++;
      $display("FAIL div1_frame_bclk got=%b exp=0", bf);
    end
    checks++;
    if (berr != 0) begin
      errors++;
      $display("FAIL div1_bclk bad_cycles=%0d exp=0", berr);
    end
    checks++;
    if ({s2, s4} !== 2'b01) begin
      errors++;
      $display("FAIL div1_msb_bits got=%b exp=01", {s2, s4});
    end
  endtask

  initial begin
    test_reset();
    test_frame_timing();
    test_pattern();
    test_sample_change();
    test_enable_drop();
    test_reset_mid();
    test_loopback();
    test_clk_div1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
